// File: rtl/imem_loader.sv
// Byte-serial instruction memory loader: assembles little-endian words from a byte stream,
// writes them into imem and holds the core in reset until the whole program is loaded.
module imem_loader #(
    parameter int DW             = 32,
    parameter int MEM_SIZE_IN_KB = 1,
    parameter int NO_OF_REGS     = MEM_SIZE_IN_KB * 1024 / 4,
    parameter int AW             = $clog2(NO_OF_REGS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [AW:0]   word_count_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_data_i,
    output logic          byte_ready_o,
    output logic          imem_we_o,
    output logic [AW-1:0] imem_addr_o,
    output logic [DW-1:0] imem_wdata_o,
    output logic          core_rst_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int BYTES = DW / 8;
    localparam int BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t          state;
    logic [BIW-1:0]  byte_idx;
    logic [AW-1:0]   word_idx;
    logic [AW:0]     count;
    logic [DW-1:0]   asm_word;
    logic [DW-1:0]   next_word;
    logic            count_legal;
    logic            last_word;

    always_comb begin
        next_word = asm_word;
        next_word[{byte_idx, 3'b000} +: 8] = byte_data_i;
    end

    assign count_legal = (word_count_i != '0) && (word_count_i <= (AW+1)'(NO_OF_REGS));
    assign last_word   = ({1'b0, word_idx} == (count - 1'b1));

    // Outputs are registered alongside the state, so each branch sets them for the state it enters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= IDLE;
            byte_idx     <= '0;
            word_idx     <= '0;
            count        <= '0;
            asm_word     <= '0;
            byte_ready_o <= 1'b0;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            imem_wdata_o <= '0;
            core_rst_o   <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        core_rst_o <= 1'b1;
                        done_o     <= 1'b0;
                        if (count_legal) begin
                            state        <= LOAD;
                            count        <= word_count_i;
                            word_idx     <= '0;
                            byte_idx     <= '0;
                            byte_ready_o <= 1'b1;
                            busy_o       <= 1'b1;
                            err_o        <= 1'b0;
                        end else begin
                            state <= ERR;
                            err_o <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (byte_valid_i && byte_ready_o) begin
                        asm_word <= next_word;
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == BIW'(BYTES - 1)) begin
                            state        <= WRITE;
                            byte_ready_o <= 1'b0;
                            imem_we_o    <= 1'b1;
                            imem_addr_o  <= word_idx;
                            imem_wdata_o <= next_word;
                        end
                    end
                end
                WRITE: begin
                    imem_we_o    <= 1'b0;
                    imem_addr_o  <= '0;
                    imem_wdata_o <= '0;
                    word_idx     <= word_idx + 1'b1;
                    if (last_word) begin
                        state      <= DONE;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        core_rst_o <= 1'b0;
                    end else begin
                        state        <= LOAD;
                        byte_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    byte_ready_o <= 1'b0;
                    imem_we_o    <= 1'b0;
                    busy_o       <= 1'b0;
                    done_o       <= 1'b0;
                    err_o        <= 1'b0;
                    core_rst_o   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: loads known programs and checks the captured
// imem writes and status outputs against hand-computed values.
module tb_imem_loader;

    localparam int NR = 256;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [AW:0]   word_count_i;
    logic          byte_valid_i;
    logic [7:0]    byte_data_i;
    logic          byte_ready_o;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [DW-1:0] imem_wdata_o;
    logic          core_rst_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    imem_loader dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .word_count_i (word_count_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .core_rst_o   (core_rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic [31:0]   mem [NR];
    int unsigned   wr_cnt = 0;
    int unsigned   rdy_viol = 0;
    logic [AW-1:0] last_addr = '0;

    logic [7:0] prog [8] = '{8'h93, 8'h01, 8'h40, 8'h00, 8'h63, 8'hC4, 8'h01, 8'h08};
    logic [7:0] prog1 [4] = '{8'h13, 8'h02, 8'h10, 8'h00};

    // Captures imem writes just after each active edge.
    always begin
        @(posedge clk_i);
        #1;
        if (imem_we_o) begin
            mem[imem_addr_o] = imem_wdata_o;
            last_addr = imem_addr_o;
            wr_cnt++;
            if (byte_ready_o) rdy_viol++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) mem[i] = 32'hDEAD_BEEF;
        wr_cnt = 0;
        rdy_viol = 0;
    endtask

    task automatic do_start(input logic [AW:0] n);
        start_i = 1'b1;
        word_count_i = n;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        while (!byte_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 64'(byte_ready_o), 64'd1);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        repeat (gap) @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        start_i = 1'b0;
        word_count_i = '0;
        byte_valid_i = 1'b0;
        byte_data_i = '0;
        clear_model();

        // 1: reset
        repeat (2) @(negedge clk_i);
        chk("rst_core_rst", 64'(core_rst_o), 64'd1);
        chk("rst_ready", 64'(byte_ready_o), 64'd0);
        chk("rst_we", 64'(imem_we_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_addr", 64'(imem_addr_o), 64'd0);
        chk("rst_wdata", 64'(imem_wdata_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // 2: two words back-to-back
        do_start(9'd2);
        chk("t2_busy", 64'(busy_o), 64'd1);
        chk("t2_ready", 64'(byte_ready_o), 64'd1);
        for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
        chk("t2_we_latency", 64'(imem_we_o), 64'd1);
        chk("t2_core_rst_in_write", 64'(core_rst_o), 64'd1);
        @(negedge clk_i);
        chk("t2_done", 64'(done_o), 64'd1);
        chk("t2_core_rst", 64'(core_rst_o), 64'd0);
        chk("t2_busy_end", 64'(busy_o), 64'd0);
        chk("t2_writes", 64'(wr_cnt), 64'd2);
        chk("t2_mem0", 64'(mem[0]), 64'h0040_0193);
        chk("t2_mem1", 64'(mem[1]), 64'h0801_C463);
        repeat (3) @(negedge clk_i);
        chk("t2_done_sticky", 64'(done_o), 64'd1);

        // 3: same stream with gaps
        clear_model();
        do_start(9'd2);
        for (int i = 0; i < 8; i++) send_byte(prog[i], 3);
        chk("t3_done", 64'(done_o), 64'd1);
        chk("t3_writes", 64'(wr_cnt), 64'd2);
        chk("t3_mem0", 64'(mem[0]), 64'h0040_0193);
        chk("t3_mem1", 64'(mem[1]), 64'h0801_C463);
        chk("t3_ready_in_write", 64'(rdy_viol), 64'd0);

        // 4: illegal counts then a legal start
        clear_model();
        do_start(9'd0);
        chk("t4_err_zero", 64'(err_o), 64'd1);
        chk("t4_done_zero", 64'(done_o), 64'd0);
        chk("t4_core_rst", 64'(core_rst_o), 64'd1);
        do_start(9'(NR + 1));
        chk("t4_err_big", 64'(err_o), 64'd1);
        chk("t4_busy_big", 64'(busy_o), 64'd0);
        repeat (2) @(negedge clk_i);
        chk("t4_err_sticky", 64'(err_o), 64'd1);
        chk("t4_writes", 64'(wr_cnt), 64'd0);
        do_start(9'd1);
        chk("t4_err_clear", 64'(err_o), 64'd0);
        chk("t4_busy", 64'(busy_o), 64'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        @(negedge clk_i);
        chk("t4_done", 64'(done_o), 64'd1);
        chk("t4_mem0", 64'(mem[0]), 64'h4433_2211);

        // 5: reset mid-load, then a fresh one-word load
        clear_model();
        do_start(9'd3);
        for (int i = 0; i < 6; i++) send_byte(prog[i], 0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk("t5_writes", 64'(wr_cnt), 64'd1);
        chk("t5_mem0", 64'(mem[0]), 64'h0040_0193);
        chk("t5_core_rst", 64'(core_rst_o), 64'd1);
        chk("t5_busy", 64'(busy_o), 64'd0);
        chk("t5_ready", 64'(byte_ready_o), 64'd0);
        @(negedge clk_i);
        do_start(9'd1);
        for (int i = 0; i < 4; i++) send_byte(prog1[i], 0);
        @(negedge clk_i);
        chk("t5_mem0_reload", 64'(mem[0]), 64'h0010_0213);
        chk("t5_done", 64'(done_o), 64'd1);
        chk("t5_writes_total", 64'(wr_cnt), 64'd2);

        // 6: start ignored during LOAD; start in DONE reloads from address 0
        clear_model();
        do_start(9'd2);
        send_byte(prog[0], 0);
        send_byte(prog[1], 0);
        do_start(9'd1);
        chk("t6_busy_after_start", 64'(busy_o), 64'd1);
        for (int i = 2; i < 8; i++) begin
            send_byte(prog[i], 0);
            if (i == 4) chk("t6_not_done_early", 64'(done_o), 64'd0);
        end
        @(negedge clk_i);
        chk("t6_done", 64'(done_o), 64'd1);
        chk("t6_writes", 64'(wr_cnt), 64'd2);
        chk("t6_mem0", 64'(mem[0]), 64'h0040_0193);
        chk("t6_mem1", 64'(mem[1]), 64'h0801_C463);
        mem[0] = 32'hDEAD_BEEF;
        do_start(9'd1);
        chk("t6_core_rst", 64'(core_rst_o), 64'd1);
        chk("t6_busy", 64'(busy_o), 64'd1);
        chk("t6_done_clear", 64'(done_o), 64'd0);
        for (int i = 0; i < 4; i++) send_byte(prog1[i], 0);
        @(negedge clk_i);
        chk("t6_reload_addr", 64'(last_addr), 64'd0);
        chk("t6_reload_mem0", 64'(mem[0]), 64'h0010_0213);
        chk("t6_reload_done", 64'(done_o), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
